// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: ALU ops, opcodes, selects, states.
// Build option MC_ADDI_EN adds the addi execute/write-back states.
package mc_pkg;

   localparam int OP_W = 6;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_OR  = 2'b10;
   localparam logic [1:0] ALU_AND = 2'b11;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

   localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
   localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
   localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
   localparam logic [OP_W-1:0] FN_AND = 6'b100100;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_TARGET = 2'b10;
   localparam logic [1:0] PCSRC_JUMP   = 2'b11;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_RWB     = 4'd7,
      S_BR_TGT  = 4'd8,
      S_BR_CMP  = 4'd9,
      S_BR_RES  = 4'd10,
      S_JUMP    = 4'd11,
      S_ADDI_EX = 4'd12,
      S_ADDI_WB = 4'd13,
      S_ILLEGAL = 4'd14
   } state_e;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       pc_write;
      logic [1:0] pc_source;
      logic       target_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] aluctrl;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       illegal;
   } ctrl_t;

   // Input-independent part of each state's outputs; ir_write, the EXEC
   // aluctrl and the BR_RES pc_write are resolved in the top.
   function automatic ctrl_t state_ctrl(state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = SRCB_FOUR;
            c.aluctrl   = ALU_ADD;
         end
         S_DECODE: begin
            c.pc_write  = 1'b1;
            c.pc_source = PCSRC_ALU;
         end
         S_MEMADR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            c.mem_read = 1'b1;
            c.iord     = 1'b1;
         end
         S_MEMWB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            c.mem_write = 1'b1;
            c.iord      = 1'b1;
         end
         S_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_B;
         end
         S_RWB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         S_BR_TGT: c.alu_src_b = SRCB_IMM_SH2;
         S_BR_CMP: begin
            c.target_write = 1'b1;
            c.alu_src_a    = 1'b1;
            c.alu_src_b    = SRCB_B;
            c.aluctrl      = ALU_SUB;
         end
         S_BR_RES: c.pc_source = PCSRC_TARGET;
         S_JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = PCSRC_JUMP;
         end
`ifdef MC_ADDI_EN
         S_ADDI_EX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
         end
         S_ADDI_WB: c.reg_write = 1'b1;
`endif
         S_ILLEGAL: c.illegal = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// R-type funct decode: ALU operation plus a flag saying the funct is supported.
module mc_alu_decode
   import mc_pkg::*;
#(
   parameter int OPW = 6
) (
   input  logic [OPW-1:0] funct_i,
   output logic [1:0]     aluctrl_o,
   output logic           funct_legal_o
);

   always_comb begin
      aluctrl_o     = ALU_ADD;
      funct_legal_o = 1'b1;
      case (funct_i)
         FN_ADD:  aluctrl_o = ALU_ADD;
         FN_SUB:  aluctrl_o = ALU_SUB;
         FN_OR:   aluctrl_o = ALU_OR;
         FN_AND:  aluctrl_o = ALU_AND;
         default: funct_legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle main controller: sequences fetch/decode/execute and drives datapath selects.
// Build option MC_ADDI_EN enables opcode 001000 (addi); otherwise it traps as illegal.
module mc_control_fsm
   import mc_pkg::*;
#(
   parameter int AW  = 32,
   parameter int OPW = 6
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [OPW-1:0] opcode,
   input  logic [OPW-1:0] funct,
   input  logic           zero,
   input  logic           mem_ready,
   output logic           mem_read,
   output logic           mem_write,
   output logic           iord,
   output logic           ir_write,
   output logic           pc_write,
   output logic [1:0]     pc_source,
   output logic           target_write,
   output logic           alu_src_a,
   output logic [1:0]     alu_src_b,
   output logic [1:0]     aluctrl,
   output logic           reg_write,
   output logic           reg_dst,
   output logic           mem_to_reg,
   output logic           illegal,
   output logic [3:0]     state
);

   if (AW < 8) begin : g_aw_check
      $error("mc_control_fsm: AW must be at least 8");
   end

   state_e     state_q, state_d;
   ctrl_t      ctrl_q;
   logic       run_q;
   logic [1:0] exec_aluctrl;
   logic       funct_legal;

   mc_alu_decode #(.OPW(OPW)) u_alu_decode (
      .funct_i       (funct),
      .aluctrl_o     (exec_aluctrl),
      .funct_legal_o (funct_legal)
   );

   // run_q holds the machine idle for the first edge after reset so that
   // outputs stay all-zero until FETCH is actually entered.
   always_comb begin
      // NOTE: state_d is defaulted before the case so no path leaves it unassigned (no latch).
      state_d = state_q;
      if (!run_q) begin
         state_d = S_FETCH;
      end else begin
         case (state_q)
            S_FETCH: if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
               case (opcode)
                  OP_RTYPE:     state_d = S_EXEC;
                  OP_LW, OP_SW: state_d = S_MEMADR;
                  OP_BEQ:       state_d = S_BR_TGT;
                  OP_J:         state_d = S_JUMP;
`ifdef MC_ADDI_EN
                  OP_ADDI:      state_d = S_ADDI_EX;
`endif
                  default:      state_d = S_ILLEGAL;
               endcase
            end
            S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:   if (mem_ready) state_d = S_FETCH;
            S_EXEC:    state_d = funct_legal ? S_RWB : S_ILLEGAL;
            S_BR_TGT:  state_d = S_BR_CMP;
            S_BR_CMP:  state_d = S_BR_RES;
`ifdef MC_ADDI_EN
            S_ADDI_EX: state_d = S_ADDI_WB;
`endif
            default:   state_d = S_FETCH;
         endcase
      end
   end

   // Outputs are registered from the next state, so they always match state_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         ctrl_q  <= '0;
         run_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         state_q <= state_d;
         ctrl_q  <= state_ctrl(state_d);
         run_q   <= 1'b1;
      end
   end

   assign mem_read     = ctrl_q.mem_read;
   assign mem_write    = ctrl_q.mem_write;
   assign iord         = ctrl_q.iord;
   assign pc_source    = ctrl_q.pc_source;
   assign target_write = ctrl_q.target_write;
   assign alu_src_a    = ctrl_q.alu_src_a;
   assign alu_src_b    = ctrl_q.alu_src_b;
   assign reg_write    = ctrl_q.reg_write;
   assign reg_dst      = ctrl_q.reg_dst;
   assign mem_to_reg   = ctrl_q.mem_to_reg;
   assign illegal      = ctrl_q.illegal;
   assign state        = state_q;

   // Input-dependent outputs; all qualified by state_q, which reset forces to FETCH.
   assign ir_write = run_q && (state_q == S_FETCH) && mem_ready;
   assign pc_write = ctrl_q.pc_write || ((state_q == S_BR_RES) && zero);
   assign aluctrl  = (state_q == S_EXEC) ? exec_aluctrl : ctrl_q.aluctrl;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench: per-instruction expected cycle sequences built from the instruction rules.
module tb_mc_control_fsm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode, funct;
   logic       zero, mem_ready;
   logic       mem_read, mem_write, iord, ir_write, pc_write;
   logic [1:0] pc_source;
   logic       target_write, alu_src_a;
   logic [1:0] alu_src_b, aluctrl;
   logic       reg_write, reg_dst, mem_to_reg, illegal;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;

`ifdef MC_ADDI_EN
   localparam bit ADDI_EN = 1'b1;
`else
   localparam bit ADDI_EN = 1'b0;
`endif

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
   localparam logic [5:0] JMP = 6'b000010, ADDI = 6'b001000;

   typedef struct packed {
      logic [3:0] st;
      logic       mem_read, mem_write, iord, ir_write, pc_write;
      logic [1:0] pc_source;
      logic       target_write, alu_src_a;
      logic [1:0] alu_src_b, aluctrl;
      logic       reg_write, reg_dst, mem_to_reg, illegal;
   } obs_t;

   obs_t       exp_q[$];
   logic       rdy_q[$];
   logic       zero_q[$];
   logic [5:0] legal_fn [4] = '{6'b100000, 6'b100010, 6'b100101, 6'b100100};

   mc_control_fsm dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
      .ir_write(ir_write), .pc_write(pc_write), .pc_source(pc_source),
      .target_write(target_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .aluctrl(aluctrl), .reg_write(reg_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   function automatic obs_t observe();
      obs_t o;
      o.st = state;                 o.mem_read = mem_read;   o.mem_write = mem_write;
      o.iord = iord;                o.ir_write = ir_write;   o.pc_write = pc_write;
      o.pc_source = pc_source;      o.target_write = target_write;
      o.alu_src_a = alu_src_a;      o.alu_src_b = alu_src_b; o.aluctrl = aluctrl;
      o.reg_write = reg_write;      o.reg_dst = reg_dst;     o.mem_to_reg = mem_to_reg;
      o.illegal = illegal;
      return o;
   endfunction

   function automatic obs_t at(int st);
      obs_t e = '0;
      e.st = 4'(st);
      return e;
   endfunction

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // ALU op for an R-type funct, or -1 when the funct is not supported.
   function automatic int r_op(logic [5:0] fn);
      case (fn)
         6'b100000: return 0;
         6'b100010: return 1;
         6'b100101: return 2;
         6'b100100: return 3;
         default:   return -1;
      endcase
   endfunction

   task automatic check(string tag, obs_t o, obs_t e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h (state %0d vs %0d)", tag, o, e, o.st, e.st);
      end
   endtask

   task automatic push(obs_t e, logic r, logic z);
      exp_q.push_back(e);
      rdy_q.push_back(r);
      zero_q.push_back(z);
   endtask

   // Expected per-cycle sequence of one instruction; sf/sm = fetch/memory stall cycles.
   task automatic build(logic [5:0] op, logic [5:0] fn, int sf, int sm, logic z);
      obs_t e;
      for (int i = 0; i <= sf; i++) begin
         e = at(0); e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = (i == sf);
         push(e, i == sf, rb());
      end
      e = at(1); e.pc_write = 1'b1; push(e, rb(), rb());
      if (op == LW || op == SW) begin
         e = at(2); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; push(e, rb(), rb());
         for (int i = 0; i <= sm; i++) begin
            e = at(op == LW ? 3 : 5); e.iord = 1'b1;
            if (op == LW) e.mem_read = 1'b1; else e.mem_write = 1'b1;
            push(e, i == sm, rb());
         end
         if (op == LW) begin
            e = at(4); e.reg_write = 1'b1; e.mem_to_reg = 1'b1; push(e, rb(), rb());
         end
      end else if (op == 6'b000000) begin
         e = at(6); e.alu_src_a = 1'b1;
         if (r_op(fn) >= 0) e.aluctrl = 2'(r_op(fn));
         push(e, rb(), rb());
         if (r_op(fn) >= 0) begin
            e = at(7); e.reg_write = 1'b1; e.reg_dst = 1'b1;
         end else begin
            e = at(14); e.illegal = 1'b1;
         end
         push(e, rb(), rb());
      end else if (op == BEQ) begin
         e = at(8); e.alu_src_b = 2'b11; push(e, rb(), rb());
         e = at(9); e.target_write = 1'b1; e.alu_src_a = 1'b1; e.aluctrl = 2'b01;
         push(e, rb(), rb());
         e = at(10); e.pc_write = z; e.pc_source = 2'b10; push(e, rb(), z);
      end else if (op == JMP) begin
         e = at(11); e.pc_write = 1'b1; e.pc_source = 2'b11; push(e, rb(), rb());
      end else if (op == ADDI && ADDI_EN) begin
         e = at(12); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; push(e, rb(), rb());
         e = at(13); e.reg_write = 1'b1; push(e, rb(), rb());
      end else begin
         e = at(14); e.illegal = 1'b1; push(e, rb(), rb());
      end
   endtask

   // Play n queued cycles (all when n < 0): drive 1 after the edge, sample 2 after.
   task automatic play(string tag, int n);
      int k;
      k = (n < 0) ? exp_q.size() : n;
      for (int i = 0; i < k; i++) begin
         @(posedge clk);
         #1;
         mem_ready = rdy_q.pop_front();
         zero      = zero_q.pop_front();
         #1 check($sformatf("%s_c%0d", tag, i), observe(), exp_q.pop_front());
      end
   endtask

   task automatic run(string tag, logic [5:0] op, logic [5:0] fn, int sf, int sm, logic z);
      opcode = op;
      funct  = fn;
      build(op, fn, sf, sm, z);
      play(tag, -1);
   endtask

   // Reset is asserted away from the edge and checked asynchronously.
   task automatic do_reset(string tag);
      mem_ready = 1'b1;
      rst_n     = 1'b0;
      #1 check({tag, "_async"}, observe(), '0);
      @(posedge clk);
      #1 check({tag, "_hold"}, observe(), '0);
      rst_n = 1'b1;
      #1 check({tag, "_release"}, observe(), '0);
      exp_q.delete();
      rdy_q.delete();
      zero_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] op, fn;
      int         kind;
      opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0; rst_n = 1'b0;
      #2;
      do_reset("reset0");

      run("rsub", 6'b000000, 6'b100010, 0, 0, 1'b0);
      run("lw_stall3", LW, 6'b0, 0, 3, 1'b0);
      run("sw", SW, 6'b0, 1, 0, 1'b0);
      run("beq_taken", BEQ, 6'b0, 0, 0, 1'b1);
      run("beq_not", BEQ, 6'b0, 0, 0, 1'b0);
      run("jump", JMP, 6'b0, 0, 0, 1'b0);
      run("ill_op", 6'b111111, 6'b0, 0, 0, 1'b0);
      run("ill_fn", 6'b000000, 6'b000000, 0, 0, 1'b0);
      run("addi", ADDI, 6'b0, 0, 0, 1'b0);

      // Abort a load during its second MEMRD stall cycle.
      opcode = LW;
      build(LW, 6'b0, 0, 3, 1'b0);
      play("lw_abort", 5);
      do_reset("reset_mid");
      run("after_abort", 6'b000000, 6'b100101, 0, 0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 6);
         fn   = 6'($urandom);
         case (kind)
            0: op = LW;
            1: op = SW;
            2: begin
               op = 6'b000000;
               if (rb()) fn = legal_fn[$urandom_range(0, 3)];
            end
            3: op = BEQ;
            4: op = JMP;
            5: op = ADDI;
            default: begin
               op = 6'($urandom);
               while (op == 6'b000000 || op == LW || op == SW || op == BEQ ||
                      op == JMP || op == ADDI)
                  op = 6'($urandom);
            end
         endcase
         run($sformatf("rnd%0d_op%02h", n, op), op, fn,
             $urandom_range(0, 2), $urandom_range(0, 3), rb());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle main controller that sequences each instruction and drives the ALU's aluctrl[1:0] and operand selects.
- Consumes the ALU's registered zero flag.
- Sits between the instruction register/memory handshake and the datapath muxes, register file and PC.
- The ALU registers result and zero on posedge clk, so every ALU result is consumed one state after it is issued.

Parameters:
- AW, 32, datapath width (informational only; no logic depends on it besides the test bench).
- OPW, 6, opcode/funct field width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag (registered by ALU).
- mem_ready  in  1  memory access complete this cycle.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- iord  out  1  memory address select: 0 = PC, 1 = ALU result.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC.
- pc_source  out  2  PC source: 00 = ALU result, 10 = target register, 11 = jump address.
- target_write  out  1  latch ALU result into the branch target register.
- alu_src_a  out  1  ALU operand A: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU operand B: 00 = B register, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- aluctrl  out  2  ALU operation: 00 = add, 01 = sub, 10 = or, 11 = and.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  destination register: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write-back source: 0 = ALU result, 1 = MDR.
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct.
- state  out  4  current state, for debug.

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous, active-low.
- Reset:
  - While rst_n = 0: state = FETCH and every output = 0, including mem_read.
  - Reset asserted mid-instruction aborts it immediately; no partial PC or register file write completes.
  - First FETCH outputs appear in the cycle after rst_n deasserts.
- Outputs are Moore, decoded from the state register.
  - Exceptions: aluctrl in EXEC decodes funct; pc_write in BR_RES is gated by zero.
  - Any output not listed for a state = 0. aluctrl defaults to 00.
- States (4-bit): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BR_TGT=8, BR_CMP=9, BR_RES=10, JUMP=11, ADDI_EX=12, ADDI_WB=13, ILLEGAL=14. Code 15 is unreachable and goes to FETCH.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, aluctrl=add.
  - ir_write = mem_ready.
  - Stays in FETCH until mem_ready = 1, then goes to DECODE.
- DECODE:
  - Outputs: pc_write=1, pc_source=00 (PC <= PC+4 registered in FETCH).
  - Next state by opcode:
    - 000000 -> EXEC
    - 100011 (lw) -> MEMADR
    - 101011 (sw) -> MEMADR
    - 000100 (beq) -> BR_TGT
    - 000010 (j) -> JUMP
    - 001000 (addi) -> ADDI_EX (only if MC_ADDI_EN)
    - anything else -> ILLEGAL
- MEMADR:
  - Outputs: alu_src_a=1, alu_src_b=10, add.
  - Next: MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, iord=1. Waits for mem_ready, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Next: FETCH.
- MEMWR: mem_write=1, iord=1. Waits for mem_ready, then FETCH.
- EXEC:
  - Outputs: alu_src_a=1, alu_src_b=00.
  - aluctrl from funct: 100000 add, 100010 sub, 100101 or, 100100 and.
  - Next: RWB. Any other funct -> ILLEGAL instead.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next: FETCH.
- BR_TGT: alu_src_a=0, alu_src_b=11, add (PC already holds PC+4). Next: BR_CMP.
- BR_CMP: target_write=1, alu_src_a=1, alu_src_b=00, sub. Next: BR_RES.
- BR_RES: pc_write = zero, pc_source=10. Next: FETCH.
- JUMP: pc_write=1, pc_source=11. Next: FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, add. Next: ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next: FETCH.
- ILLEGAL: illegal=1 for exactly one cycle. Next: FETCH; PC has already advanced.
- Boundary conditions:
  - mem_ready is ignored in non-waiting states.
  - mem_ready held high continuously: each memory state takes exactly 1 cycle.
  - Cycle counts with mem_ready=1: lw 5, sw 4, R-type 4, beq 5, j 3, addi 4.

Optional Feature:
- Macro MC_ADDI_EN.
- Defined: opcode 001000 executes via ADDI_EX/ADDI_WB.
- Undefined: ADDI states are not generated; opcode 001000 -> ILLEGAL; codes 12/13 are unreachable and go to FETCH.

Decomposition:
- Package mc_pkg holds:
  - ALU op constants ALU_ADD/SUB/OR/AND.
  - Opcode and funct constants.
  - State enum encodings.
  - alu_src_b and pc_source select encodings.
- One sub-module, mc_alu_decode: combinational funct -> {aluctrl, funct_legal}, used in EXEC.

Test Plan:
- Reset: rst_n=0 mid-MEMRD -> state=0 and all outputs 0 in the same cycle; after release, FETCH with mem_read=1.
- R-type sub: opcode 000000, funct 100010, mem_ready=1 -> states 0,1,6,7,0; aluctrl=01 in EXEC; reg_write=1 and reg_dst=1 in RWB.
- lw with 3-cycle memory stall in MEMRD: mem_ready low 3 cycles -> stays in state 3 with mem_read=1 and iord=1; MEMWB asserts reg_write with mem_to_reg=1; total 8 cycles.
- beq, run twice:
  - zero=1 in BR_RES -> pc_write=1, pc_source=10.
  - zero=0 -> pc_write=0.
  - Both runs: target_write=1 in BR_CMP only.
- Illegal input: opcode 111111 -> illegal=1 for exactly 1 cycle, then FETCH. Funct 000000 in EXEC -> same.
- addi 001000: with MC_ADDI_EN -> states 12 then 13, reg_write=1 in 13; without the macro -> ILLEGAL pulse.
